fg_config_loader: RTL and testbench



---
 rtl/fg_config_if.sv | 9 +
 rtl/fg_config_loader.sv | 135 +++++++++++++
 tb/tb_fg_config_loader.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fg_config_if.sv
// rtl/fg_config_if.sv - byte stream handshake between a config source and fg_config_loader
interface fg_config_if;
  logic [7:0] data_i;
  logic       dataValid_STRB_i;
  logic       ready_o;

  modport master (output data_i, output dataValid_STRB_i, input ready_o);
  modport slave  (input data_i, input dataValid_STRB_i, output ready_o);
endinterface

// File: rtl/fg_config_loader.sv
// rtl/fg_config_loader.sv - framed byte-stream loader committing the generator config word; FG_CONFIG_CHECKSUM_EN adds the XOR checksum byte
module fg_config_loader #(
  parameter int         CONFIG_REG_BITWIDTH = 56,
  parameter int         TIMEOUT_CYCLES      = 255,
  parameter logic [6:0] HEADER_TAG          = 7'b1010010
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  fg_config_if.slave                     cfg,
  input  logic                           outValid_STRB_i,
  output logic [CONFIG_REG_BITWIDTH-1:0] CR_bus_o,
  output logic                           enable_o,
  output logic                           busy_o,
  output logic                           commit_STRB_o,
  output logic                           error_o
);

  localparam int PAYLOAD_BYTES = CONFIG_REG_BITWIDTH / 8;
  localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

`ifdef FG_CONFIG_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_WAIT_SYNC, S_COMMIT} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_SYNC, S_COMMIT} state_t;
`endif

  state_t                         state;
  logic [CONFIG_REG_BITWIDTH-1:0] shadow;
  logic                           en_latch;
  logic [IDX_W-1:0]               idx;
  logic [TO_W-1:0]                to_cnt;
  logic                           accept;
  logic                           timeout_hit;
  state_t                         sync_target;
`ifdef FG_CONFIG_CHECKSUM_EN
  logic [7:0]                     csum;
`endif

  // Waiting for COMMIT is only needed while ready/backpressure can stall the stream: not in WAIT_SYNC or COMMIT
  assign cfg.ready_o = (state != S_WAIT_SYNC) && (state != S_COMMIT);
  assign busy_o      = (state != S_IDLE);
  assign accept      = cfg.dataValid_STRB_i & cfg.ready_o;
  // A disabled timeout (0) never fires; the counter then just wraps harmlessly
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);
  // A running generator must only see a new config on a sample boundary
  assign sync_target = enable_o ? S_WAIT_SYNC : S_COMMIT;

  // Frame FSM: assembles the shadow word and commits it atomically to the outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      shadow        <= '0;
      en_latch      <= 1'b0;
      idx           <= '0;
      to_cnt        <= '0;
      CR_bus_o      <= '0;
      enable_o      <= 1'b0;
      commit_STRB_o <= 1'b0;
      error_o       <= 1'b0;
`ifdef FG_CONFIG_CHECKSUM_EN
      csum          <= 8'h00;
`endif
    end else begin
      commit_STRB_o <= 1'b0;
      error_o       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (cfg.data_i[7:1] == HEADER_TAG) begin
              en_latch <= cfg.data_i[0];
              idx      <= '0;
              to_cnt   <= '0;
`ifdef FG_CONFIG_CHECKSUM_EN
              csum     <= cfg.data_i;
`endif
              state    <= S_LOAD;
            end else begin
              error_o <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            shadow <= {shadow[CONFIG_REG_BITWIDTH-9:0], cfg.data_i};
            to_cnt <= '0;
            idx    <= idx + 1'b1;
`ifdef FG_CONFIG_CHECKSUM_EN
            csum   <= csum ^ cfg.data_i;
            if (idx == IDX_LAST) state <= S_CHECK;
`else
            if (idx == IDX_LAST) state <= sync_target;
`endif
          end else if (timeout_hit) begin
            error_o <= 1'b1;
            state   <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
`ifdef FG_CONFIG_CHECKSUM_EN
        S_CHECK: begin
          if (accept) begin
            to_cnt <= '0;
            if (cfg.data_i == csum) begin
              state <= sync_target;
            end else begin
              error_o <= 1'b1;
              state   <= S_IDLE;
            end
          end else if (timeout_hit) begin
            error_o <= 1'b1;
            state   <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
`endif
        S_WAIT_SYNC: begin
          if (outValid_STRB_i) state <= S_COMMIT;
        end
        S_COMMIT: begin
          CR_bus_o      <= shadow;
          enable_o      <= en_latch;
          commit_STRB_o <= 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fg_config_loader.sv
// tb/tb_fg_config_loader.sv - self-checking bench for fg_config_loader
module tb_fg_config_loader;

  localparam logic [6:0] TAG = 7'b1010010;
`ifdef FG_CONFIG_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef logic [7:0] byteq_t[$];
  typedef struct {
    logic [7:0]  hdr;
    logic [55:0] payload;
    bit          corrupt;
    int          exp_err;
    int          exp_com;
    logic [55:0] exp_cr;
    bit          exp_en;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        outValid_STRB_i;
  logic [55:0] CR_bus_o;
  logic        enable_o;
  logic        busy_o;
  logic        commit_STRB_o;
  logic        error_o;

  int checks = 0;
  int failures = 0;
  int err_pulses = 0;
  int commit_pulses = 0;
  logic [55:0] m_cr;
  logic        m_en;
  vec_t        vecs[6];

  fg_config_if stream ();

  fg_config_loader dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .cfg             (stream),
    .outValid_STRB_i (outValid_STRB_i),
    .CR_bus_o        (CR_bus_o),
    .enable_o        (enable_o),
    .busy_o          (busy_o),
    .commit_STRB_o   (commit_STRB_o),
    .error_o         (error_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (error_o) err_pulses++;
    if (commit_STRB_o) commit_pulses++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic byteq_t build_frame(input logic [7:0] hdr, input logic [55:0] pl, input bit corrupt);
    byteq_t q;
    logic [7:0] x;
    q.push_back(hdr);
    if (hdr[7:1] != TAG) return q;
    for (int i = 6; i >= 0; i--) q.push_back(pl[i*8 +: 8]);
    if (CSUM) begin
      x = 8'h00;
      foreach (q[i]) x ^= q[i];
      if (corrupt) x ^= 8'h01;
      q.push_back(x);
    end
    return q;
  endfunction

  // Reference: a frame either errors (bad tag / bad checksum) or commits its payload and enable bit
  task automatic model_frame(input byteq_t q, output int e_err, output int e_com);
    logic [7:0]  x;
    logic [55:0] pl;
    logic [7:0]  h;
    e_err = 0;
    e_com = 0;
    h = q[0];
    if (h[7:1] != TAG) begin
      e_err = 1;
      return;
    end
    if (CSUM) begin
      x = 8'h00;
      for (int i = 0; i < q.size() - 1; i++) x ^= q[i];
      if (x != q[q.size()-1]) begin
        e_err = 1;
        return;
      end
    end
    pl = '0;
    for (int i = 1; i <= 7; i++) pl = {pl[47:0], q[i]};
    m_cr  = pl;
    m_en  = h[0];
    e_com = 1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    stream.data_i = b;
    stream.dataValid_STRB_i = 1'b1;
    while (!stream.ready_o && n < 400) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!stream.ready_o) begin
      checks++;
      failures++;
      $display("FAIL send_ready_timeout ready=0 required=1");
    end
    @(posedge clk_i); #1;
  endtask

  task automatic send_frame(input byteq_t q, input int gap_max);
    foreach (q[i]) begin
      send_byte(q[i]);
      stream.dataValid_STRB_i = 1'b0;
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk_i); #1; end
    end
  endtask

  task automatic wait_idle(input bit rand_sync);
    int n = 0;
    while (busy_o && n < 300) begin
      if (rand_sync) outValid_STRB_i = ($urandom_range(0, 3) == 0);
      @(posedge clk_i); #1;
      n++;
    end
    if (rand_sync) outValid_STRB_i = 1'b0;
    if (busy_o) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout busy=1 required=0");
    end
  endtask

  task automatic run_frame(input logic [7:0] hdr, input logic [55:0] pl, input bit corrupt, input int gap_max,
                           input bit rand_sync, output int d_err, output int d_com, output int e_err, output int e_com);
    byteq_t q;
    int e0, c0;
    q = build_frame(hdr, pl, corrupt);
    model_frame(q, e_err, e_com);
    e0 = err_pulses;
    c0 = commit_pulses;
    send_frame(q, gap_max);
    wait_idle(rand_sync);
    repeat (2) begin @(posedge clk_i); #1; end
    d_err = err_pulses - e0;
    d_com = commit_pulses - c0;
  endtask

  initial begin
    byteq_t q;
    int d_err, d_com, e_err, e_com, viol, err_at, err_cycles;
    logic [7:0]  hdr;
    logic [55:0] pl;
    bit corrupt;
    int r;

    vecs[0] = '{8'hA5, 56'h40036420101000, 1'b0, 0, 1, 56'h40036420101000, 1'b1};
`ifdef FG_CONFIG_CHECKSUM_EN
    vecs[1] = '{8'hA5, 56'h40036420101000, 1'b1, 1, 0, 56'h40036420101000, 1'b1};
`else
    vecs[1] = '{8'hA5, 56'h40036420101000, 1'b1, 0, 1, 56'h40036420101000, 1'b1};
`endif
    vecs[2] = '{8'h77, 56'h0, 1'b0, 1, 0, 56'h40036420101000, 1'b1};
    vecs[3] = '{8'hA4, 56'h0123456789ABCD, 1'b0, 0, 1, 56'h0123456789ABCD, 1'b0};
    vecs[4] = '{8'hA5, 56'hFFFFFFFFFFFFFF, 1'b0, 0, 1, 56'hFFFFFFFFFFFFFF, 1'b1};
    vecs[5] = '{8'hA4, 56'h0, 1'b0, 0, 1, 56'h0, 1'b0};

    rst_i = 1'b1;
    outValid_STRB_i = 1'b0;
    stream.data_i = 8'h00;
    stream.dataValid_STRB_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    check("rst_cr", CR_bus_o, 0);
    check("rst_en", enable_o, 0);
    check("rst_commit", commit_STRB_o, 0);
    check("rst_err", error_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ready", stream.ready_o, 1);

    // Commit latency with enable_o == 0: outputs and strobe one edge after the last byte
    q = build_frame(8'hA5, 56'h40036420101000, 1'b0);
    foreach (q[i]) send_byte(q[i]);
    stream.dataValid_STRB_i = 1'b0;
    check("lat_k_commit", commit_STRB_o, 0);
    check("lat_k_ready", stream.ready_o, 0);
    check("lat_k_cr", CR_bus_o, 0);
    @(posedge clk_i); #1;
    check("lat_k1_commit", commit_STRB_o, 1);
    check("lat_k1_cr", CR_bus_o, 56'h40036420101000);
    check("lat_k1_en", enable_o, 1);
    check("lat_k1_ready", stream.ready_o, 1);
    check("lat_k1_busy", busy_o, 0);
    @(posedge clk_i); #1;
    check("lat_k2_commit", commit_STRB_o, 0);

    // enable_o == 1: commit held in WAIT_SYNC until a sample strobe
    q = build_frame(8'hA4, 56'h11223344556677, 1'b0);
    send_frame(q, 0);
    viol = 0;
    repeat (20) begin
      @(posedge clk_i); #1;
      if (stream.ready_o || commit_STRB_o || !busy_o) viol++;
    end
    check("sync_hold_violations", viol, 0);
    check("sync_hold_cr", CR_bus_o, 56'h40036420101000);
    outValid_STRB_i = 1'b1;
    @(posedge clk_i); #1;
    outValid_STRB_i = 1'b0;
    check("sync_commit_state_ready", stream.ready_o, 0);
    check("sync_commit_state_cr", CR_bus_o, 56'h40036420101000);
    @(posedge clk_i); #1;
    check("sync_commit_strobe", commit_STRB_o, 1);
    check("sync_commit_cr", CR_bus_o, 56'h11223344556677);
    check("sync_commit_en", enable_o, 0);

    // Inter-byte timeout after 3 payload bytes
    q = build_frame(8'hA5, 56'hDEADBEEF123456, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_byte(q[i]);
      stream.dataValid_STRB_i = 1'b0;
    end
    err_at = -1;
    err_cycles = 0;
    for (int c = 1; c <= 270; c++) begin
      @(posedge clk_i); #1;
      if (error_o) begin
        err_cycles++;
        if (err_at < 0) err_at = c;
      end
    end
    check("timeout_in_window", (err_at >= 250 && err_at <= 260), 1);
    check("timeout_err_cycles", err_cycles, 1);
    check("timeout_busy", busy_o, 0);
    check("timeout_cr", CR_bus_o, 56'h11223344556677);
    check("timeout_en", enable_o, 0);

    // Reset in the middle of a frame
    q = build_frame(8'hA5, 56'hCAFEF00D998877, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(q[i]);
    stream.dataValid_STRB_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("midrst_cr", CR_bus_o, 0);
    check("midrst_en", enable_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_ready", stream.ready_o, 1);
    check("midrst_err", error_o, 0);
    check("midrst_commit", commit_STRB_o, 0);
    m_cr = '0;
    m_en = 1'b0;

    // Directed vector table, generator strobing every cycle
    outValid_STRB_i = 1'b1;
    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].hdr, vecs[v].payload, vecs[v].corrupt, 0, 1'b0, d_err, d_com, e_err, e_com);
      check($sformatf("vec%0d_err", v), d_err, vecs[v].exp_err);
      check($sformatf("vec%0d_commit", v), d_com, vecs[v].exp_com);
      check($sformatf("vec%0d_cr", v), CR_bus_o, vecs[v].exp_cr);
      check($sformatf("vec%0d_en", v), enable_o, vecs[v].exp_en);
      check($sformatf("vec%0d_busy", v), busy_o, 0);
    end
    outValid_STRB_i = 1'b0;

    // Random frames against the reference model
    for (int f = 0; f < 40; f++) begin
      r = $urandom_range(0, 99);
      corrupt = (r >= 15 && r < 30);
      if (r < 15) begin
        hdr = 8'($urandom);
        while (hdr[7:1] == TAG) hdr = 8'($urandom);
      end else begin
        hdr = {TAG, 1'($urandom)};
      end
      pl = {24'($urandom), 32'($urandom)};
      run_frame(hdr, pl, corrupt, 3, 1'b1, d_err, d_com, e_err, e_com);
      check($sformatf("rnd%0d_err", f), d_err, e_err);
      check($sformatf("rnd%0d_commit", f), d_com, e_com);
      check($sformatf("rnd%0d_cr", f), CR_bus_o, m_cr);
      check($sformatf("rnd%0d_en", f), enable_o, m_en);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
